fc_snapshot_reader: RTL and testbench

FC_SNAPSHOT_READER -- requirements
Module: fc_snapshot_reader

---
 rtl/fc_snapshot_reader.sv | 149 ++++++++++++++
 tb/tb_fc_snapshot_reader.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/fc_snapshot_reader.sv
// Reads a consistent snapshot of the frequency-counter registers over a simple
// valid/ready bus, bracketing the counters with two epoch reads and retrying on change.
module fc_snapshot_reader #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000,
    parameter int          TIMEOUT   = 255,
    parameter int          MAX_RETRY = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic        iomem_valid,
    input  logic        iomem_ready,
    output logic [3:0]  iomem_wstrb,
    output logic [31:0] iomem_addr,
    output logic [31:0] iomem_wdata,
    input  logic [31:0] iomem_rdata,
    output logic [31:0] ref_sys_cnt,
    output logic [31:0] sig_cnt,
    output logic [31:0] sig_sys_cnt,
    output logic [31:0] epoch,
    output logic [1:0]  fsm_state
);

    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    typedef enum logic [1:0] {IDLE, REQ, GAP, CHECK} state_t;

    state_t        state;
    logic [2:0]    rd_idx;
    logic [TW-1:0] to_cnt;
    logic [RW-1:0] retries;
    logic [31:0]   sh_epoch_a;
    logic [31:0]   sh_epoch_b;
    logic [31:0]   sh_ref;
    logic [31:0]   sh_sig;
    logic [31:0]   sh_sig_sys;
    logic [7:0]    offset;

    assign busy        = (state != IDLE);
    assign fsm_state   = state;
    assign iomem_wstrb = 4'b0000;
    assign iomem_wdata = 32'h0;
    assign iomem_addr  = BASE_ADDR | {24'h0, offset};

    // The epoch register is read first and last so a rollover mid-sequence is detectable.
    always_comb begin
        offset = 8'h10;
        case (rd_idx)
            3'd1:    offset = 8'h04;
            3'd2:    offset = 8'h08;
            3'd3:    offset = 8'h0c;
            default: offset = 8'h10;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            rd_idx      <= 3'd0;
            to_cnt      <= '0;
            retries     <= '0;
            iomem_valid <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= 2'b00;
            sh_epoch_a  <= 32'h0;
            sh_epoch_b  <= 32'h0;
            sh_ref      <= 32'h0;
            sh_sig      <= 32'h0;
            sh_sig_sys  <= 32'h0;
            ref_sys_cnt <= 32'h0;
            sig_cnt     <= 32'h0;
            sig_sys_cnt <= 32'h0;
            epoch       <= 32'h0;
        end else begin
            done  <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= REQ;
                        iomem_valid <= 1'b1;
                        rd_idx      <= 3'd0;
                        retries     <= '0;
                        to_cnt      <= '0;
                    end
                end
                REQ: begin
                    if (iomem_ready) begin
                        iomem_valid <= 1'b0;
                        state       <= GAP;
                        case (rd_idx)
                            3'd0:    sh_epoch_a <= iomem_rdata;
                            3'd1:    sh_ref     <= iomem_rdata;
                            3'd2:    sh_sig     <= iomem_rdata;
                            3'd3:    sh_sig_sys <= iomem_rdata;
                            default: sh_epoch_b <= iomem_rdata;
                        endcase
                    end else if (to_cnt == TW'(TIMEOUT - 1)) begin
                        iomem_valid <= 1'b0;
                        error       <= 1'b1;
                        err_code    <= 2'b01;
                        state       <= IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                GAP: begin
                    if (rd_idx == 3'd4) begin
                        state <= CHECK;
                    end else begin
                        rd_idx      <= rd_idx + 3'd1;
                        iomem_valid <= 1'b1;
                        to_cnt      <= '0;
                        state       <= REQ;
                    end
                end
                CHECK: begin
                    if (sh_epoch_a == sh_epoch_b) begin
                        ref_sys_cnt <= sh_ref;
                        sig_cnt     <= sh_sig;
                        sig_sys_cnt <= sh_sig_sys;
                        epoch       <= sh_epoch_a;
                        done        <= 1'b1;
                        state       <= IDLE;
                    end else if (retries < RW'(MAX_RETRY)) begin
                        // The CHECK cycle itself serves as the gap before the retry read.
                        retries     <= retries + 1'b1;
                        rd_idx      <= 3'd0;
                        iomem_valid <= 1'b1;
                        to_cnt      <= '0;
                        state       <= REQ;
                    end else begin
                        error    <= 1'b1;
                        err_code <= 2'b10;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fc_snapshot_reader.sv
// Randomized bench for fc_snapshot_reader: a queue-driven responder, a pass-level
// reference model, and a monitor that scores every read and every done/error pulse.
module tb_fc_snapshot_reader;

    localparam logic [31:0] BASE = 32'h0300_0000;
    localparam int          W    = 132;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic        iomem_valid;
    logic        rsp_ready = 1'b0;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr, iomem_wdata;
    logic [31:0] rsp_rdata = 32'h0;
    logic [31:0] ref_sys_cnt, sig_cnt, sig_sys_cnt, epoch;
    logic [1:0]  fsm_state;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   exp_addr_q[$];
    logic [31:0]   rsp_q[$];
    logic          rsp_en = 1'b1;
    logic [127:0]  last_snap = '0;
    logic [1:0]    last_code = 2'b00;
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    int            n_reads = 0;
    int            ev_cnt = 0;
    int            last_ev_edge = 0;
    int            start_edge = 0;

    fc_snapshot_reader dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .error(error), .err_code(err_code), .iomem_valid(iomem_valid),
        .iomem_ready(rsp_ready), .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(rsp_rdata), .ref_sys_cnt(ref_sys_cnt),
        .sig_cnt(sig_cnt), .sig_sys_cnt(sig_sys_cnt), .epoch(epoch), .fsm_state(fsm_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // responder: ready one cycle after valid, data taken from rsp_q in order
    always @(posedge clk) begin
        if (!reset && rsp_en && iomem_valid && !rsp_ready) begin
            rsp_ready <= 1'b1;
            if (rsp_q.size() > 0) rsp_rdata <= rsp_q.pop_front();
            else                  rsp_rdata <= $urandom;
        end else begin
            rsp_ready <= 1'b0;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (iomem_valid && rsp_ready) begin
                n_reads++;
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got addr %0h expected no read", iomem_addr);
                end else begin
                    chk("read_addr", iomem_addr, exp_addr_q.pop_front());
                end
            end
            if (done || error) begin
                logic [W-1:0] e;
                ev_cnt++;
                last_ev_edge = cyc;
                chk("done_error_exclusive", done && error, 0);
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_event: got done=%0b error=%0b expected none", done, error);
                end else begin
                    e = exp_q.pop_front();
                    chk("event_kind", {done, error}, e[131:130]);
                    chk("err_code", err_code, e[129:128]);
                    chk("snapshot", {ref_sys_cnt, sig_cnt, sig_sys_cnt, epoch}, e[127:0]);
                end
            end
        end
    end

    // driver tasks
    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        start_edge = cyc;
    endtask

    task automatic push_addrs();
        exp_addr_q.push_back(BASE | 32'h10);
        exp_addr_q.push_back(BASE | 32'h04);
        exp_addr_q.push_back(BASE | 32'h08);
        exp_addr_q.push_back(BASE | 32'h0c);
        exp_addr_q.push_back(BASE | 32'h10);
    endtask

    task automatic wait_event(input int ev0, input int budget, input string name);
        int i;
        for (i = 0; i < budget; i++) begin
            if (ev_cnt != ev0) break;
            @(negedge clk);
        end
        chk(name, ev_cnt != ev0, 1);
    endtask

    // One snapshot request; the first n_mm passes see the epoch change between
    // the two epoch reads. Expected outcome follows from the retry budget of 3.
    task automatic run_snapshot(input logic [31:0] ep0, input int n_mm, input bit extra_start);
        logic [31:0] cur, eb, r, s, ss;
        int passes, ev0, r0;
        cur = ep0;
        passes = (n_mm > 3) ? 4 : n_mm + 1;
        for (int p = 0; p < passes; p++) begin
            r = $urandom; s = $urandom; ss = $urandom;
            eb = (p < n_mm) ? cur + 32'd1 : cur;
            rsp_q.push_back(cur); rsp_q.push_back(r); rsp_q.push_back(s);
            rsp_q.push_back(ss); rsp_q.push_back(eb);
            push_addrs();
            if (p == passes - 1 && n_mm <= 3) last_snap = {r, s, ss, cur};
            cur = eb;
        end
        if (n_mm > 3) last_code = 2'b10;
        exp_q.push_back({(n_mm > 3) ? 2'b01 : 2'b10, last_code, last_snap});
        ev0 = ev_cnt; r0 = n_reads;
        do_start();
        if (extra_start) begin
            repeat (3) @(negedge clk);
            start = 1'b1; @(negedge clk); start = 1'b0;
        end
        wait_event(ev0, 200, "snapshot_complete");
        repeat (10) @(negedge clk);
        chk("read_count", n_reads - r0, 5 * passes);
        chk("idle_after", busy, 0);
        chk("queues_drained", exp_q.size() + exp_addr_q.size(), 0);
    endtask

    initial begin
        int ev0, r0, vcnt;
        reset = 1'b1; start = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_valid", iomem_valid, 0);
        chk("reset_done_error", {done, error}, 0);
        chk("reset_err_code", err_code, 0);
        chk("reset_snapshot", {ref_sys_cnt, sig_cnt, sig_sys_cnt, epoch}, 0);
        chk("tied_write_lines", {iomem_wstrb, iomem_wdata}, 0);
        reset = 1'b0;

        // directed nominal read with latency measurement
        rsp_q.push_back(32'd5); rsp_q.push_back(32'd10_000_000); rsp_q.push_back(32'd9_999_998);
        rsp_q.push_back(32'd10_000_003); rsp_q.push_back(32'd5);
        push_addrs();
        last_snap = {32'd10_000_000, 32'd9_999_998, 32'd10_000_003, 32'd5};
        exp_q.push_back({2'b10, last_code, last_snap});
        ev0 = ev_cnt; r0 = n_reads;
        do_start();
        wait_event(ev0, 100, "nominal_complete");
        chk("done_latency", last_ev_edge - start_edge, 16);
        chk("nominal_reads", n_reads - r0, 5);

        run_snapshot(32'd5, 1, 1'b0);
        run_snapshot($urandom, 4, 1'b0);
        for (int k = 0; k < 10; k++) run_snapshot($urandom, $urandom_range(0, 4), 1'b1);

        // responder silent: timeout path
        rsp_en = 1'b0;
        last_code = 2'b01;
        exp_q.push_back({2'b01, last_code, last_snap});
        ev0 = ev_cnt; vcnt = 0;
        do_start();
        for (int i = 0; i < 400; i++) begin
            if (iomem_valid) vcnt++;
            if (ev_cnt != ev0) break;
            @(negedge clk);
        end
        chk("timeout_event", ev_cnt != ev0, 1);
        chk("timeout_valid_cycles", vcnt, 255);
        chk("timeout_busy", busy, 0);
        rsp_en = 1'b1;
        @(negedge clk);

        // extra start while busy, then reset during the third read
        repeat (5) rsp_q.push_back($urandom);
        push_addrs();
        ev0 = ev_cnt; r0 = n_reads;
        do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (n_reads - r0 == 2 && iomem_valid) break;
            @(negedge clk);
        end
        chk("third_read_reached", (n_reads - r0 == 2) && iomem_valid, 1);
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", iomem_valid, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_snapshot", {ref_sys_cnt, sig_cnt, sig_sys_cnt, epoch}, 0);
        chk("rst_mid_err_code", err_code, 0);
        chk("rst_mid_no_event", ev_cnt - ev0, 0);
        rsp_q.delete(); exp_addr_q.delete();
        last_snap = '0; last_code = 2'b00;
        reset = 1'b0;
        run_snapshot($urandom, 0, 1'b0);
        run_snapshot($urandom, $urandom_range(1, 3), 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
